// File: rtl/udp_pkg.sv
// Shared definitions for the UDP user-side blocks: meta layout, FSM states, helpers.
package udp_pkg;

  localparam int unsigned IP_LSB    = 0;
  localparam int unsigned RPORT_LSB = 128;
  localparam int unsigned LPORT_LSB = 144;
  localparam int unsigned LEN_LSB   = 160;
  localparam int unsigned META_W    = 176;

  // Field order is MSB first, so len lands at [175:160] and ip at [127:0].
  typedef struct packed {
    logic [15:0]  len;
    logic [15:0]  lport;
    logic [15:0]  rport;
    logic [127:0] ip;
  } udp_meta_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_META,
    ST_DATA,
    ST_DROP
  } udp_state_t;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      cnt = cnt + {6'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/udp_echo_responder.sv
// Echoes each accepted UDP datagram back to its sender; drops empty, oversize
// or disabled traffic and keeps saturating status counters.
module udp_echo_responder
  import udp_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1472
) (
  input  logic              axis_clk,
  input  logic              axis_rstn,
  input  logic              enable,

  input  logic              s_axis_rx_udp_meta_tvalid,
  output logic              s_axis_rx_udp_meta_tready,
  input  logic [META_W-1:0] s_axis_rx_udp_meta_tdata,

  input  logic              s_axis_rx_udp_data_tvalid,
  output logic              s_axis_rx_udp_data_tready,
  input  logic [511:0]      s_axis_rx_udp_data_tdata,
  input  logic [63:0]       s_axis_rx_udp_data_tkeep,
  input  logic              s_axis_rx_udp_data_tlast,

  output logic              m_axis_tx_udp_meta_tvalid,
  input  logic              m_axis_tx_udp_meta_tready,
  output logic [META_W-1:0] m_axis_tx_udp_meta_tdata,

  output logic              m_axis_tx_udp_data_tvalid,
  input  logic              m_axis_tx_udp_data_tready,
  output logic [511:0]      m_axis_tx_udp_data_tdata,
  output logic [63:0]       m_axis_tx_udp_data_tkeep,
  output logic              m_axis_tx_udp_data_tlast,

  output logic [31:0]       echo_count,
  output logic [31:0]       drop_count,
  output logic [31:0]       len_err_count
);

  udp_state_t state_q, state_d;
  udp_meta_t  meta_q;
  udp_meta_t  meta_in;
  logic [15:0] acc_q;
  logic [15:0] acc_sum;
  logic        rdy_q;
  logic        meta_hs;
  logic        rx_beat;
  logic        len_bad;

  assign meta_in  = udp_meta_t'(s_axis_rx_udp_meta_tdata);
  assign meta_hs  = s_axis_rx_udp_meta_tvalid && s_axis_rx_udp_meta_tready;
  assign rx_beat  = s_axis_rx_udp_data_tvalid && s_axis_rx_udp_data_tready;
  assign acc_sum  = acc_q + {9'd0, popcount64(s_axis_rx_udp_data_tkeep)};
  assign len_bad  = (32'(meta_in.len) > MAX_LEN) || !enable;

  assign m_axis_tx_udp_meta_tdata = meta_q;

  // Next-state decode and handshake/pass-through outputs.
  always_comb begin
    state_d                   = state_q;
    s_axis_rx_udp_meta_tready = 1'b0;
    s_axis_rx_udp_data_tready = 1'b0;
    m_axis_tx_udp_meta_tvalid = 1'b0;
    m_axis_tx_udp_data_tvalid = 1'b0;
    m_axis_tx_udp_data_tdata  = '0;
    m_axis_tx_udp_data_tkeep  = '0;
    m_axis_tx_udp_data_tlast  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // rdy_q keeps tready low until the cycle after reset is released.
        s_axis_rx_udp_meta_tready = rdy_q;
        if (meta_hs) begin
          if (meta_in.len == 16'd0) state_d = ST_IDLE;
          else if (len_bad)         state_d = ST_DROP;
          else                      state_d = ST_META;
        end
      end
      ST_META: begin
        m_axis_tx_udp_meta_tvalid = 1'b1;
        if (m_axis_tx_udp_meta_tready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m_axis_tx_udp_data_tvalid = s_axis_rx_udp_data_tvalid;
        m_axis_tx_udp_data_tdata  = s_axis_rx_udp_data_tdata;
        m_axis_tx_udp_data_tkeep  = s_axis_rx_udp_data_tkeep;
        m_axis_tx_udp_data_tlast  = s_axis_rx_udp_data_tlast;
        s_axis_rx_udp_data_tready = m_axis_tx_udp_data_tready;
        if (rx_beat && s_axis_rx_udp_data_tlast) state_d = ST_IDLE;
      end
      ST_DROP: begin
        s_axis_rx_udp_data_tready = 1'b1;
        if (rx_beat && s_axis_rx_udp_data_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, meta register, byte accumulator and saturating counters.
  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) begin
      state_q       <= ST_IDLE;
      meta_q        <= '0;
      acc_q         <= '0;
      rdy_q         <= 1'b0;
      echo_count    <= '0;
      drop_count    <= '0;
      len_err_count <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (meta_hs) meta_q <= meta_in;

      if (state_q == ST_META && m_axis_tx_udp_meta_tready) acc_q <= '0;
      else if (state_q == ST_DATA && rx_beat)               acc_q <= acc_sum;

      if ((state_q == ST_IDLE && meta_hs && meta_in.len == 16'd0) ||
          (state_q == ST_DROP && rx_beat && s_axis_rx_udp_data_tlast)) begin
        if (drop_count != '1) drop_count <= drop_count + 32'd1;
      end

      if (state_q == ST_DATA && rx_beat && s_axis_rx_udp_data_tlast) begin
        if (echo_count != '1) echo_count <= echo_count + 32'd1;
        if (acc_sum != meta_q.len && len_err_count != '1)
          len_err_count <= len_err_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_echo_responder.sv
// Directed bench for udp_echo_responder: echo, drop paths, length error,
// randomised backpressure stream and mid-datagram reset.
module tb_udp_echo_responder;

  logic         clk = 1'b0;
  logic         rstn;
  logic         enable;
  logic         s_meta_tvalid;
  logic         s_meta_tready;
  logic [175:0] s_meta_tdata;
  logic         s_data_tvalid;
  logic         s_data_tready;
  logic [511:0] s_data_tdata;
  logic [63:0]  s_data_tkeep;
  logic         s_data_tlast;
  logic         m_meta_tvalid;
  logic         m_meta_tready;
  logic [175:0] m_meta_tdata;
  logic         m_data_tvalid;
  logic         m_data_tready;
  logic [511:0] m_data_tdata;
  logic [63:0]  m_data_tkeep;
  logic         m_data_tlast;
  logic [31:0]  echo_count, drop_count, len_err_count;

  logic bp_rand;
  logic rnd_meta_rdy, rnd_data_rdy;
  assign m_meta_tready = bp_rand ? rnd_meta_rdy : 1'b1;
  assign m_data_tready = bp_rand ? rnd_data_rdy : 1'b1;

  udp_echo_responder #(.MAX_LEN(1472)) dut (
    .axis_clk                  (clk),
    .axis_rstn                 (rstn),
    .enable                    (enable),
    .s_axis_rx_udp_meta_tvalid (s_meta_tvalid),
    .s_axis_rx_udp_meta_tready (s_meta_tready),
    .s_axis_rx_udp_meta_tdata  (s_meta_tdata),
    .s_axis_rx_udp_data_tvalid (s_data_tvalid),
    .s_axis_rx_udp_data_tready (s_data_tready),
    .s_axis_rx_udp_data_tdata  (s_data_tdata),
    .s_axis_rx_udp_data_tkeep  (s_data_tkeep),
    .s_axis_rx_udp_data_tlast  (s_data_tlast),
    .m_axis_tx_udp_meta_tvalid (m_meta_tvalid),
    .m_axis_tx_udp_meta_tready (m_meta_tready),
    .m_axis_tx_udp_meta_tdata  (m_meta_tdata),
    .m_axis_tx_udp_data_tvalid (m_data_tvalid),
    .m_axis_tx_udp_data_tready (m_data_tready),
    .m_axis_tx_udp_data_tdata  (m_data_tdata),
    .m_axis_tx_udp_data_tkeep  (m_data_tkeep),
    .m_axis_tx_udp_data_tlast  (m_data_tlast),
    .echo_count                (echo_count),
    .drop_count                (drop_count),
    .len_err_count             (len_err_count)
  );

  always #5 clk = ~clk;

  // Random TX readiness, updated shortly after each rising edge.
  initial begin
    rnd_meta_rdy = 1'b1;
    rnd_data_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      rnd_meta_rdy = ($urandom_range(0, 2) != 0);
      rnd_data_rdy = ($urandom_range(0, 2) != 0);
    end
  end

  // Observed TX traffic, RX beat consumption and TX meta stability while stalled.
  logic [175:0] txm_q[$];
  logic [576:0] txd_q[$];
  int unsigned  rx_beats = 0;
  int unsigned  stall_viol = 0;
  logic         prev_stall = 1'b0;
  logic [175:0] prev_meta = '0;
  always @(posedge clk) begin
    if (m_meta_tvalid && m_meta_tready) txm_q.push_back(m_meta_tdata);
    if (m_data_tvalid && m_data_tready) txd_q.push_back({m_data_tlast, m_data_tkeep, m_data_tdata});
    if (s_data_tvalid && s_data_tready) rx_beats++;
    if (rstn && prev_stall && (!m_meta_tvalid || m_meta_tdata !== prev_meta)) stall_viol++;
    prev_stall <= rstn && m_meta_tvalid && !m_meta_tready;
    prev_meta  <= m_meta_tdata;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [703:0] obs, input logic [703:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put_meta(input logic [175:0] m);
    int unsigned t;
    bit done;
    t = 0;
    done = 0;
    @(negedge clk);
    s_meta_tvalid = 1'b1;
    s_meta_tdata  = m;
    while (!done && t < 300) begin
      if (s_meta_tready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (!done) check("meta_handshake_timeout", 704'(done), 704'(1));
    #1;
    s_meta_tvalid = 1'b0;
  endtask

  task automatic put_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int unsigned t;
    bit done;
    t = 0;
    done = 0;
    @(negedge clk);
    s_data_tvalid = 1'b1;
    s_data_tdata  = d;
    s_data_tkeep  = k;
    s_data_tlast  = l;
    while (!done && t < 300) begin
      if (s_data_tready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    if (!done) check("data_handshake_timeout", 704'(done), 704'(1));
    #1;
    s_data_tvalid = 1'b0;
  endtask

  function automatic logic [175:0] mk_meta(input logic [127:0] ip, input logic [15:0] rp,
                                           input logic [15:0] lp, input logic [15:0] len);
    return {len, lp, rp, ip};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [63:0] keep_of(input int unsigned bytes);
    logic [63:0] one;
    one = 64'd1;
    if (bytes >= 64) return '1;
    return (one << bytes) - 64'd1;
  endfunction

  logic [175:0] exp_m[$];
  logic [576:0] exp_d[$];

  initial begin
    logic [175:0] m;
    logic [511:0] d0, d1;
    int unsigned bm, bd, br;

    bp_rand = 1'b0;
    rstn = 1'b0;
    enable = 1'b1;
    s_meta_tvalid = 1'b0;
    s_meta_tdata = '0;
    s_data_tvalid = 1'b0;
    s_data_tdata = '0;
    s_data_tkeep = '0;
    s_data_tlast = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_meta_tready", 704'(s_meta_tready), 704'(0));
    check("rst_data_tready", 704'(s_data_tready), 704'(0));
    check("rst_tx_meta_tvalid", 704'(m_meta_tvalid), 704'(0));
    check("rst_tx_data_tvalid", 704'(m_data_tvalid), 704'(0));
    check("rst_tx_meta_tdata", 704'(m_meta_tdata), 704'(0));
    check("rst_counters", 704'({echo_count, drop_count, len_err_count}), 704'(0));
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_meta_tready", 704'(s_meta_tready), 704'(1));

    // 1: basic echo, 10.0.0.2:5000 -> port 7, len 100 = 64 + 36
    bm = txm_q.size(); bd = txd_q.size();
    m  = mk_meta(128'h0A00_0002, 16'd5000, 16'd7, 16'd100);
    d0 = rnd512();
    d1 = rnd512();
    put_meta(m);
    @(negedge clk);
    check("t1_meta_latency_valid", 704'(m_meta_tvalid), 704'(1));
    check("t1_meta_tdata", 704'(m_meta_tdata), 704'(m));
    check("t1_meta_state_rx_tready", 704'({s_meta_tready, s_data_tready}), 704'(0));
    put_beat(d0, '1, 1'b0);
    put_beat(d1, 64'h0000_000F_FFFF_FFFF, 1'b1);
    repeat (2) @(negedge clk);
    check("t1_tx_meta_count", 704'(txm_q.size() - bm), 704'(1));
    check("t1_tx_meta_word", 704'(txm_q[bm]), 704'(m));
    check("t1_tx_beat_count", 704'(txd_q.size() - bd), 704'(2));
    check("t1_tx_beat0", 704'(txd_q[bd]), 704'({1'b0, 64'hFFFF_FFFF_FFFF_FFFF, d0}));
    check("t1_tx_beat1", 704'(txd_q[bd+1]), 704'({1'b1, 64'h0000_000F_FFFF_FFFF, d1}));
    check("t1_echo_count", 704'(echo_count), 704'(1));
    check("t1_len_err_count", 704'(len_err_count), 704'(0));

    // 2: oversize len 2000, 32 beats consumed silently
    bm = txm_q.size(); bd = txd_q.size(); br = rx_beats;
    put_meta(mk_meta(128'h0A00_0003, 16'd1234, 16'd7, 16'd2000));
    @(negedge clk);
    check("t2_drop_state_outputs", 704'({s_data_tready, m_meta_tvalid, s_meta_tready}), 704'(3'b100));
    for (int i = 0; i < 32; i++) put_beat(rnd512(), '1, i == 31);
    repeat (2) @(negedge clk);
    check("t2_rx_beats_consumed", 704'(rx_beats - br), 704'(32));
    check("t2_no_tx_activity", 704'({txm_q.size() - bm, txd_q.size() - bd}), 704'(0));
    check("t2_drop_count", 704'(drop_count), 704'(1));

    // 3: zero length, then len 64 with enable low
    put_meta(mk_meta(128'h0A00_0004, 16'd1, 16'd7, 16'd0));
    @(negedge clk);
    check("t3_len0_drop_count", 704'(drop_count), 704'(2));
    check("t3_len0_stays_idle", 704'(s_meta_tready), 704'(1));
    br = rx_beats;
    enable = 1'b0;
    put_meta(mk_meta(128'h0A00_0005, 16'd2, 16'd7, 16'd64));
    enable = 1'b1;
    put_beat(rnd512(), '1, 1'b1);
    repeat (2) @(negedge clk);
    check("t3_disabled_drop_count", 704'(drop_count), 704'(3));
    check("t3_disabled_beat_consumed", 704'(rx_beats - br), 704'(1));
    check("t3_no_tx_activity", 704'({txm_q.size() - bm, txd_q.size() - bd}), 704'(0));

    // 4: len 100 but only 64 bytes of tkeep
    m  = mk_meta(128'h0A00_0006, 16'd3, 16'd7, 16'd100);
    d0 = rnd512();
    put_meta(m);
    put_beat(d0, '1, 1'b1);
    repeat (2) @(negedge clk);
    check("t4_echo_count", 704'(echo_count), 704'(2));
    check("t4_len_err_count", 704'(len_err_count), 704'(1));
    check("t4_tx_meta_word", 704'(txm_q[bm]), 704'(m));
    check("t4_tx_beat", 704'(txd_q[bd]), 704'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF, d0}));

    // 5: 50 datagrams under random TX backpressure
    bm = txm_q.size(); bd = txd_q.size();
    exp_m.delete();
    exp_d.delete();
    bp_rand = 1'b1;
    for (int k = 0; k < 50; k++) begin
      int unsigned len, nb;
      len = $urandom_range(1, 300);
      nb  = (len + 63) / 64;
      m   = mk_meta({$urandom, $urandom, $urandom, $urandom}, 16'($urandom), 16'($urandom), 16'(len));
      exp_m.push_back(m);
      put_meta(m);
      for (int b = 0; b < int'(nb); b++) begin
        logic [63:0] kp;
        logic        lst;
        lst = (b == int'(nb) - 1);
        kp  = lst ? keep_of(len - 64 * (nb - 1)) : '1;
        d0  = rnd512();
        exp_d.push_back({lst, kp, d0});
        put_beat(d0, kp, lst);
      end
    end
    repeat (20) @(negedge clk);
    bp_rand = 1'b0;
    check("t5_meta_count", 704'(txm_q.size() - bm), 704'(exp_m.size()));
    check("t5_beat_count", 704'(txd_q.size() - bd), 704'(exp_d.size()));
    for (int i = 0; i < exp_m.size() && bm + i < txm_q.size(); i++)
      check($sformatf("t5_meta_%0d", i), 704'(txm_q[bm + i]), 704'(exp_m[i]));
    for (int i = 0; i < exp_d.size() && bd + i < txd_q.size(); i++)
      check($sformatf("t5_beat_%0d", i), 704'(txd_q[bd + i]), 704'(exp_d[i]));
    check("t5_echo_count", 704'(echo_count), 704'(52));
    check("t5_len_err_count", 704'(len_err_count), 704'(1));
    check("t5_meta_stable_while_stalled", 704'(stall_viol), 704'(0));

    // 6: reset after beat 1 of 3
    put_meta(mk_meta(128'h0A00_0007, 16'd9, 16'd7, 16'd150));
    put_beat(rnd512(), '1, 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    s_data_tvalid = 1'b1;
    s_data_tdata  = rnd512();
    s_data_tkeep  = '1;
    s_data_tlast  = 1'b0;
    @(negedge clk);
    check("t6_rst_tvalids", 704'({m_meta_tvalid, m_data_tvalid}), 704'(0));
    check("t6_rst_tx_data", 704'({m_data_tlast, m_data_tkeep, m_data_tdata}), 704'(0));
    check("t6_rst_tx_meta_tdata", 704'(m_meta_tdata), 704'(0));
    check("t6_rst_readies", 704'({s_meta_tready, s_data_tready}), 704'(0));
    check("t6_rst_counters", 704'({echo_count, drop_count, len_err_count}), 704'(0));
    s_data_tvalid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("t6_post_rst_meta_tready", 704'(s_meta_tready), 704'(1));
    bm = txm_q.size(); bd = txd_q.size();
    m  = mk_meta(128'h0A00_0008, 16'd10, 16'd7, 16'd64);
    d0 = rnd512();
    put_meta(m);
    put_beat(d0, '1, 1'b1);
    repeat (2) @(negedge clk);
    check("t6_tx_meta_word", 704'(txm_q[bm]), 704'(m));
    check("t6_tx_beat", 704'(txd_q[bd]), 704'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF, d0}));
    check("t6_counters_restart", 704'({echo_count, drop_count, len_err_count}), 704'({32'd1, 32'd0, 32'd0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
